// File: rtl/mips_prog_loader_if.sv
// Byte-stream input, ROM write port and core-control outputs of the program loader.
interface mips_prog_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;
  logic              cpu_n_rst;
  logic              done;
  logic              err;

  // Host / bench side
  modport master (
    output start, in_valid, in_data,
    input  in_ready, rom_we, rom_addr, rom_wdata, cpu_n_rst, done, err
  );

  // Loader side
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, rom_we, rom_addr, rom_wdata, cpu_n_rst, done, err
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Boot loader for the mips core: takes a 16-bit word count followed by big-endian
// instruction words over a byte stream, writes them into the instruction ROM, then
// releases the core from reset after a short hold.
module mips_prog_loader #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RST_HOLD = 2
) (
  input logic              clk,
  input logic              n_rst,
  mips_prog_loader_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {StIdle, StHdr, StLoad, StHold, StRun, StErr} state_e;

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [7:0]        hdr_hi_q;
  logic [23:0]       word_q;     // first three bytes of the word being assembled
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   remain_q;   // words still to be written, up to Depth
  logic [3:0]        hold_cnt_q;

  logic              in_ready_q;
  logic              rom_we_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [31:0]       rom_wdata_q;
  logic              cpu_n_rst_q;
  logic              done_q;
  logic              err_q;

  logic        accept;
  logic [15:0] hdr_n;

  assign accept = bus.in_valid && in_ready_q;
  assign hdr_n  = {hdr_hi_q, bus.in_data};

  // Loader FSM with all outputs registered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      hdr_hi_q    <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      remain_q    <= '0;
      hold_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_n_rst_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rom_we_q <= 1'b0;
      unique case (state_q)
        StIdle, StRun, StErr: begin
          if (bus.start) begin
            state_q     <= StHdr;
            in_ready_q  <= 1'b1;
            byte_cnt_q  <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            cpu_n_rst_q <= 1'b0;
            done_q      <= 1'b0;
          end
        end
        StHdr: begin
          if (accept) begin
            if (byte_cnt_q == 2'd0) begin
              hdr_hi_q   <= bus.in_data;
              byte_cnt_q <= 2'd1;
            end else begin
              byte_cnt_q <= 2'd0;
              remain_q   <= hdr_n[ADDR_W:0];
              if (hdr_n == 16'd0) begin
                state_q    <= StHold;
                in_ready_q <= 1'b0;
                hold_cnt_q <= '0;
              end else if ({1'b0, hdr_n} > 17'(Depth)) begin
                state_q    <= StErr;
                in_ready_q <= 1'b0;
                err_q      <= 1'b1;
              end else begin
                state_q <= StLoad;
              end
            end
          end
        end
        StLoad: begin
          if (accept) begin
            if (byte_cnt_q == 2'd3) begin
              rom_we_q    <= 1'b1;
              rom_addr_q  <= idx_q;
              rom_wdata_q <= {word_q, bus.in_data};
              idx_q       <= idx_q + 1'b1;  // wraps to 0 after a full-depth load
              byte_cnt_q  <= 2'd0;
              remain_q    <= remain_q - 1'b1;
              if (remain_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                state_q    <= StHold;
                in_ready_q <= 1'b0;
                hold_cnt_q <= '0;
              end
            end else begin
              word_q     <= {word_q[15:0], bus.in_data};
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        StHold: begin
          if (hold_cnt_q == 4'(RST_HOLD - 1)) begin
            state_q     <= StRun;
            cpu_n_rst_q <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.cpu_n_rst = cpu_n_rst_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomised bench for the program loader: a ROM image model built from the
// program contents is compared against what the loader actually writes.
module tb_mips_prog_loader;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned RST_HOLD = 2;
  localparam int          DEPTH    = 2 ** ADDR_W;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic clk = 1'b0;
  logic n_rst;

  mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_prog_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed ROM image and per-load write log
  logic [31:0] rom_seen  [DEPTH];
  logic [31:0] rom_model [DEPTH];
  int          we_addr_q[$];
  logic [31:0] we_data_q[$];
  int cyc = 0;
  int last_we_cyc, last_acc_cyc, rise_cyc, acc_cnt;
  logic prev_cpu = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.rom_we) begin
        rom_seen[bus.rom_addr] = bus.rom_wdata;
        we_addr_q.push_back(int'(bus.rom_addr));
        we_data_q.push_back(bus.rom_wdata);
        last_we_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        last_acc_cyc = cyc + 1;
        acc_cnt++;
      end
      if (bus.cpu_n_rst && !prev_cpu) rise_cyc = cyc;
    end
    prev_cpu = bus.cpu_n_rst;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pre);
    check_eq({pre, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check_eq({pre, "_rom_we"},    32'(bus.rom_we),    32'd0);
    check_eq({pre, "_rom_addr"},  32'(bus.rom_addr),  32'd0);
    check_eq({pre, "_rom_wdata"}, bus.rom_wdata,      32'd0);
    check_eq({pre, "_cpu_n_rst"}, 32'(bus.cpu_n_rst), 32'd0);
    check_eq({pre, "_done"},      32'(bus.done),      32'd0);
    check_eq({pre, "_err"},       32'(bus.err),       32'd0);
  endtask

  // Offer bytes in order with random idle cycles; a byte advances only when taken
  task automatic send(input byte_q_t b, input int gap);
    int i = 0;
    int budget = 0;
    while (i < b.size() && budget < 4000) begin
      tick();
      budget++;
      if (int'($urandom_range(99)) < gap) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b[i];
        if (bus.in_ready) i++;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    check_eq("send_all_taken", 32'(i), 32'(b.size()));
  endtask

  task automatic check_rom(input string tag);
    int bad = 0;
    for (int a = 0; a < DEPTH; a++) if (rom_seen[a] !== rom_model[a]) bad++;
    check_eq({tag, "_rom_image_bad_words"}, 32'(bad), 32'd0);
  endtask

  // Load a program (start already issued); optional start pulse after `split` bytes
  task automatic run_load(input string tag, input word_q_t words, input int gap,
                          input int split);
    byte_q_t b, b2;
    int n = words.size();
    int waited = 0;
    we_addr_q.delete();
    we_data_q.delete();
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    foreach (words[k]) for (int s = 3; s >= 0; s--) b.push_back(8'(words[k] >> (8 * s)));
    if (split > 0) begin
      for (int k = split; k < b.size(); k++) b2.push_back(b[k]);
      b = b[0:split-1];
      send(b, gap);
      pulse_start();
      check_eq({tag, "_start_in_load_ignored"}, 32'(bus.in_ready), 32'd1);
      send(b2, gap);
    end else begin
      send(b, gap);
    end
    while (!bus.cpu_n_rst && waited < 300) begin
      tick();
      waited++;
    end
    check_eq({tag, "_core_released"}, 32'(bus.cpu_n_rst), 32'd1);
    tick();
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
    check_eq({tag, "_we_pulses"}, 32'(we_addr_q.size()), 32'(n));
    for (int k = 0; k < n && k < we_addr_q.size(); k++) begin
      check_eq({tag, "_addr"}, 32'(we_addr_q[k]), 32'(k % DEPTH));
      check_eq({tag, "_data"}, we_data_q[k], words[k]);
    end
    for (int k = 0; k < n; k++) rom_model[k % DEPTH] = words[k];
    check_eq({tag, "_hold_cycles"},
             32'(rise_cyc - ((n > 0) ? last_we_cyc : last_acc_cyc)), 32'(RST_HOLD));
    check_rom(tag);
  endtask

  initial begin
    word_q_t w;
    byte_q_t b;
    int acc_before;
    for (int a = 0; a < DEPTH; a++) begin
      rom_seen[a]  = 32'd0;
      rom_model[a] = 32'd0;
    end
    n_rst        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    n_rst = 1'b1;
    tick();
    check_eq("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // 1: two-word program
    pulse_start();
    check_eq("start_in_ready", 32'(bus.in_ready), 32'd1);
    w = '{32'h20080007, 32'hAC080004};
    run_load("t1", w, 0, 0);

    // 2: empty program, started from RUN
    pulse_start();
    check_eq("t2_run_start_cpu_n_rst", 32'(bus.cpu_n_rst), 32'd0);
    check_eq("t2_run_start_done", 32'(bus.done), 32'd0);
    w = {};
    run_load("t2", w, 30, 0);

    // 3: header one past ROM depth
    pulse_start();
    we_addr_q.delete();
    b = '{8'h00, 8'h41};
    send(b, 0);
    check_eq("t3_err", 32'(bus.err), 32'd1);
    check_eq("t3_in_ready", 32'(bus.in_ready), 32'd0);
    acc_before = acc_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    check_eq("t3_no_accept", 32'(acc_cnt - acc_before), 32'd0);
    check_eq("t3_no_we", 32'(we_addr_q.size()), 32'd0);
    check_eq("t3_cpu_n_rst", 32'(bus.cpu_n_rst), 32'd0);
    pulse_start();
    check_eq("t3_err_cleared", 32'(bus.err), 32'd0);
    check_eq("t3_hdr_ready", 32'(bus.in_ready), 32'd1);

    // 4: full-depth random program with random gaps
    w = {};
    for (int k = 0; k < DEPTH; k++) w.push_back($urandom);
    run_load("t4", w, 40, 0);

    // 6: start in RUN, then a start pulse mid-load that must be ignored
    pulse_start();
    check_eq("t6_run_start_cpu_n_rst", 32'(bus.cpu_n_rst), 32'd0);
    w = {};
    for (int k = 0; k < 3; k++) w.push_back($urandom);
    run_load("t6", w, 20, 7);

    // 5: reset after five payload bytes; first word already written
    pulse_start();
    we_addr_q.delete();
    w = {};
    for (int k = 0; k < 3; k++) w.push_back($urandom);
    b = '{8'h00, 8'h03};
    for (int s = 3; s >= 0; s--) b.push_back(8'(w[0] >> (8 * s)));
    b.push_back(8'(w[1] >> 24));
    send(b, 25);
    check_eq("t5_partial_we", 32'(we_addr_q.size()), 32'd1);
    rom_model[0] = w[0];
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("t5_mid_reset");
    #2 n_rst = 1'b1;
    tick();
    check_eq("t5_still_held", 32'(bus.cpu_n_rst), 32'd0);
    check_rom("t5_partial");
    pulse_start();
    w = '{$urandom};
    run_load("t5_reload", w, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
